// File: rtl/fpu_pipe_seq_if.sv
// Handshake and status bundle between the issuing unit and the FP pipe sequencer.
interface fpu_pipe_seq_if #(
    parameter int STAGES = 5,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 8
);
    logic               start;
    logic [TAG_W-1:0]   tag_in;
    logic               ready;
    logic               mode;
    logic               stall;
    logic               flush;
    logic [STAGES-1:0]  stage_en;
    logic               done;
    logic [TAG_W-1:0]   done_tag;
    logic               flag;
    logic               busy;
    logic [CNT_W-1:0]   ops_done;

    // Issuing unit side
    modport master (
        output start, tag_in, mode, stall, flush,
        input  ready, stage_en, done, done_tag, flag, busy, ops_done
    );

    // Sequencer side
    modport slave (
        input  start, tag_in, mode, stall, flush,
        output ready, stage_en, done, done_tag, flag, busy, ops_done
    );
endinterface

// File: rtl/fpu_pipe_seq.sv
// Stage sequencer for the FP datapaths: a valid/tag shift register tracks ops
// in flight, driving per-stage load enables, a completion strobe with its tag,
// a sticky result flag and a wrapping completion counter.
module fpu_pipe_seq #(
    parameter int STAGES = 5,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    fpu_pipe_seq_if.slave bus
);
    logic [STAGES-1:0]            vld_pipe;
    logic [STAGES-1:0][TAG_W-1:0] tag_pipe;
    logic                         mode_q;
    logic                         flag_q;
    logic [CNT_W-1:0]             cnt_q;

    logic busy;
    logic ready;
    logic accept;
    logic advance;
    logic done;

    // Flush outranks stall; either one freezes movement through the stages.
    assign advance = ~bus.stall & ~bus.flush;
    assign busy    = |vld_pipe;
    // Sequential mode admits a new op only once the pipe has fully drained.
    assign ready   = advance & (mode_q | ~busy);
    assign accept  = bus.start & ready & ~bus.flush;
    assign done    = vld_pipe[STAGES-1] & advance;

    assign bus.ready    = ready;
    assign bus.busy     = busy;
    assign bus.stage_en = vld_pipe & {STAGES{advance}};
    assign bus.done     = done;
    assign bus.done_tag = tag_pipe[STAGES-1];
    assign bus.flag     = flag_q;
    assign bus.ops_done = cnt_q;

    // Valid shift register: cleared by flush, frozen by stall, else shifts in accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_pipe <= '0;
        else if (bus.flush)
            vld_pipe <= '0;
        else if (!bus.stall)
            vld_pipe <= {vld_pipe[STAGES-2:0], accept};
    end

    // Tag shift register moves in lockstep with the valids; contents are don't-care on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tag_pipe <= '0;
        else if (advance)
            tag_pipe <= {tag_pipe[STAGES-2:0], bus.tag_in};
    end

    // Mode is sampled only while idle so in-flight ops never see a mode change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mode_q <= 1'b0;
        else if (!busy)
            mode_q <= bus.mode;
    end

    // Sticky result flag: completion wins over a coincident new issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flag_q <= 1'b0;
        else if (done)
            flag_q <= 1'b1;
        else if (accept)
            flag_q <= 1'b0;
    end

    // Completed-op counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (done)
            cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: tb/tb_fpu_pipe_seq.sv
// Scoreboard bench for fpu_pipe_seq: the driver records each issued op with its
// issue cycle; the monitor derives due/stage positions from elapsed non-stalled
// cycles and compares every output each cycle.
module tb_fpu_pipe_seq;
    localparam int STAGES = 5;
    localparam int TAG_W  = 4;
    localparam int CNT_W  = 8;

    typedef struct {
        logic [TAG_W-1:0] tag;
        int               issue;
        int               s0;
    } op_t;

    logic clk;
    logic rst_n;

    fpu_pipe_seq_if #(.STAGES(STAGES), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

    fpu_pipe_seq #(.STAGES(STAGES), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    op_t q[$];
    int  cyc = 0;
    int  stall_total = 0;
    logic mode_m = 1'b0;
    logic p_accept = 1'b0, p_stall = 1'b0, p_flush = 1'b0, p_busy = 1'b0, p_mode = 1'b0;
    logic [TAG_W-1:0] p_tag = '0;
    logic cur_ready = 1'b1, cur_accept = 1'b0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus: fold the previous cycle into the model, then drive new inputs.
    task automatic step(input logic s, input logic [TAG_W-1:0] t, input logic m,
                        input logic st, input logic fl);
        @(posedge clk);
        #1;
        cyc++;
        if (!p_busy) mode_m = p_mode;
        if (p_flush) q.delete();
        else begin
            if (p_stall) stall_total++;
            if (p_accept) q.push_back('{p_tag, cyc - 1, stall_total});
        end
        bus.start  = s;
        bus.tag_in = t;
        bus.mode   = m;
        bus.stall  = st;
        bus.flush  = fl;
        cur_ready  = !st && !fl && (mode_m || q.size() == 0);
        cur_accept = s && cur_ready;
        p_accept = cur_accept;
        p_stall  = st;
        p_flush  = fl;
        p_busy   = (q.size() != 0);
        p_mode   = m;
        p_tag    = t;
    endtask

    task automatic idle(input int n, input logic m);
        for (int i = 0; i < n; i++) step(1'b0, '0, m, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        q.delete();
        mode_m = 1'b0;
        p_accept = 1'b0; p_stall = 1'b0; p_flush = 1'b0; p_busy = 1'b0; p_mode = 1'b0;
        p_tag = '0;
        cur_ready = 1'b1;
        cur_accept = 1'b0;
    endtask

    task automatic chk_cleared(input string name);
        chk({name, "_done"},     32'(bus.done), 0);
        chk({name, "_done_tag"}, 32'(bus.done_tag), 0);
        chk({name, "_busy"},     32'(bus.busy), 0);
        chk({name, "_stage_en"}, 32'(bus.stage_en), 0);
        chk({name, "_flag"},     32'(bus.flag), 0);
        chk({name, "_ops_done"}, 32'(bus.ops_done), 0);
        chk({name, "_ready"},    32'(bus.ready), 1);
    endtask

    // Monitor: per-cycle comparison against the scoreboard of in-flight ops.
    logic [CNT_W-1:0]  ops_exp = '0;
    logic              flag_exp = 1'b0;
    always @(negedge clk) begin
        logic adv, due;
        logic [STAGES-1:0] en_exp;
        int e;
        if (!rst_n) begin
            flag_exp = 1'b0;
            ops_exp  = '0;
        end else if (mon_en) begin
            adv = !bus.stall && !bus.flush;
            en_exp = '0;
            foreach (q[i]) begin
                e = cyc - q[i].issue - (stall_total - q[i].s0);
                if (adv && e >= 1 && e <= STAGES) en_exp[e-1] = 1'b1;
            end
            due = (q.size() > 0) && adv &&
                  (cyc - q[0].issue - (stall_total - q[0].s0) == STAGES);
            chk("ready",    32'(bus.ready), 32'(cur_ready));
            chk("busy",     32'(bus.busy), 32'(q.size() != 0));
            chk("stage_en", 32'(bus.stage_en), 32'(en_exp));
            chk("done",     32'(bus.done), 32'(due));
            chk("flag",     32'(bus.flag), 32'(flag_exp));
            chk("ops_done", 32'(bus.ops_done), 32'(ops_exp));
            if (due) begin
                chk("done_tag", 32'(bus.done_tag), 32'(q[0].tag));
                void'(q.pop_front());
                flag_exp = 1'b1;
                ops_exp  = ops_exp + 1'b1;
            end else if (cur_accept) begin
                flag_exp = 1'b0;
            end
        end
    end

    initial begin
        bus.start = 1'b0; bus.tag_in = '0; bus.mode = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Sequential single op, tag 3
        step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        idle(STAGES + 2, 1'b0);

        // Pipelined burst, tags 0..7
        for (int i = 0; i < 8; i++) step(1'b1, TAG_W'(i), 1'b1, 1'b0, 1'b0);
        idle(STAGES + 2, 1'b1);

        // Back-to-back issue with a two-cycle stall
        for (int i = 1; i <= 3; i++) step(1'b1, TAG_W'(i), 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'd7, 1'b1, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        idle(STAGES + 3, 1'b1);

        // Flush with three in flight, then immediate re-issue
        for (int i = 4; i <= 6; i++) step(1'b1, TAG_W'(i), 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'd8, 1'b1, 1'b1, 1'b1);
        step(1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
        idle(STAGES + 2, 1'b1);

        // Randomised traffic; long pipelined runs push ops_done through its wrap
        begin
            logic m;
            m = 1'b1;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 99) < 4) m = ~m;
                step($urandom_range(0, 99) < 70, TAG_W'($urandom),  m,
                     $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3);
            end
        end
        idle(STAGES + 3, 1'b0);

        // Asynchronous reset with an op in stage 2
        step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cleared("async_rst");
        bus.start = 1'b0; bus.tag_in = '0; bus.mode = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Fresh op after reset completes with normal latency
        step(1'b1, 4'd11, 1'b0, 1'b0, 1'b0);
        idle(STAGES + 3, 1'b0);

        chk("drain", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_pipe_seq.md
# fpu_pipe_seq

Parametrised stage sequencer for the floating-point pipelines (FPM/FPA). It tracks operations in flight through a STAGES-deep datapath and issues per-stage register enables, a completion pulse with the returning tag, and a sticky completion flag. It supersedes the fixed five-state single-shot controller. It adds true back-to-back issue, a start/ready handshake, stall, flush, a sequential/pipelined mode and a completion counter. It sits between the issuing unit and the datapath stage registers.

## Interface
Parameters:
- STAGES, 5: datapath depth. Legal range 2..16.
- TAG_W, 4: width of the tag carried alongside each operation.
- CNT_W, 8: width of the completed-operation counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: issue request; operands are valid this cycle.
- tag_in, input, TAG_W: tag for the issued operation.
- ready, output, 1: sequencer accepts `start` this cycle.
- mode, input, 1: 0 = sequential (one op in flight), 1 = pipelined.
- stall, input, 1: freeze all stages.
- flush, input, 1: synchronously discard all in-flight operations.
- stage_en, output, STAGES: bit k loads stage-k output register this cycle.
- done, output, 1: one-cycle completion strobe.
- done_tag, output, TAG_W: tag of the completing op; valid while `done`.
- flag, output, 1: sticky "result available".
- busy, output, 1: any op in flight.
- ops_done, output, CNT_W: completed-op count; wraps modulo 2^CNT_W.

## Operation
- State is a valid shift register v[STAGES-1:0] with a parallel tag shift register. There is no encoded FSM.
- accept = start & ready & ~flush.
- ready = ~stall & ~flush & (mode_q | ~busy).
- busy = |v.
- mode_q is a registered copy of `mode`. It is loaded only when busy=0, so mode changes while ops are in flight have no effect until the pipe drains.
- Normal cycle (no stall, no flush): v[0] <= accept; v[k] <= v[k-1]; tags shift identically, with tag[0] <= tag_in.
- Stall without flush: v and tags hold. `start` is ignored because ready=0.
- Flush has priority over stall and start: v <= 0, tags unchanged (don't-care), no accept.
- stage_en[k] = v[k] & ~stall & ~flush. This is combinational.
- done = v[STAGES-1] & ~stall & ~flush; done_tag = tag[STAGES-1].
- ops_done increments by 1 on every `done`; wraps from 2^CNT_W-1 to 0.
- flag next-state, in priority order:
  - `done` sets it to 1;
  - otherwise `accept` clears it to 0;
  - otherwise it holds.
- A same-cycle `done` and `accept` leaves flag set.
- Reset (asynchronous, any time including mid-operation):
  - v=0, tags=0, mode_q=0, flag=0, ops_done=0;
  - hence stage_en=0, done=0, done_tag=0, busy=0.
  - ready = ~stall & ~flush as soon as rst_n is high.
  - In-flight ops are lost; no `done` is produced for them.

## Timing
- Accept in cycle 0 gives stage_en[k] high in cycle k+1 (absent stall).
- `done` is high in cycle STAGES. Latency from accept to done is STAGES cycles.
- Each stall cycle adds exactly one cycle of latency to every in-flight op.
- Pipelined mode: issue interval 1; sustained throughput 1 op/cycle; done_tag order equals issue order.
- Sequential mode: ready is low from the cycle after accept through the `done` cycle. The next accept is possible in cycle STAGES+1, so the issue interval is STAGES+1.
- flag rises one cycle after `done` and falls one cycle after a non-coincident accept.
- ops_done updates one cycle after `done`.

## Test plan
- Reset, then STAGES=5, mode=0, start with tag_in=3 in cycle 0:
  - stage_en = 00001, 00010, … 10000 in cycles 1–5;
  - done=1, done_tag=3 in cycle 5;
  - ready=0 in cycles 1–5;
  - flag=1 and ops_done=1 from cycle 6.
- mode=1, start held for 8 cycles, tags 0..7: done in cycles 5..12 with tags 0..7 in order; ready stays 1; ops_done=8.
- mode=1, issue tags 1,2,3 back-to-back, stall=1 for cycles 3–4: done_tag 1,2,3 appear in cycles 7,8,9; stage_en=0 and ready=0 during the stall.
- Three ops in flight, flush in cycle 2: busy=0 from cycle 3; no `done` follows; ops_done unchanged; accept possible in cycle 3.
- CNT_W=2, run 5 ops: ops_done sequence 1,2,3,0,1.
- Assert rst_n=0 mid-operation (op in stage 2): all outputs clear asynchronously; no `done` after release; a new op completes with normal latency.
